// File: rtl/simple_tx.sv
// Store-and-forward framer: buffers one stream packet, then emits SFD/type/size/payload/FCS; optional SIMPLE_TX_IFG_EN adds a 12-cycle inter-frame gap.
// Latency: frame starts one cycle after the tlast handshake; txd_out/txdv_out are registered.
// Backpressure: tready_out is high only while idle; there is no backpressure on the line side.
module simple_tx #(
    parameter int G_MEM_SIZE = 100  // payload buffer depth in bytes, 8..255 (size byte is 8 bits)
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  tdata_in,
    input  logic        tvalid_in,
    input  logic        tlast_in,
    output logic        tready_out,
    output logic [7:0]  txd_out,
    output logic        txdv_out,
    output logic [15:0] stat_packet_vld_cnt,
    output logic [15:0] stat_packet_err_cnt
);

    localparam int CNT_W = $clog2(G_MEM_SIZE + 1);
    localparam int IDX_W = (CNT_W > 4) ? CNT_W : 4;

    typedef enum logic [2:0] {
        IDLE,
        PCK_SFD,
        PCK_TYPE,
        PCK_SIZE,
        PCK_PAYLOAD,
        PCK_FCS,
        PCK_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       mem [G_MEM_SIZE];
    logic [CNT_W-1:0] byte_cnt;
    logic             oversize;
    logic [CNT_W-1:0] pkt_len;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [7:0]       fcs, fcs_nxt;
    logic [7:0]       txd_nxt;
    logic             txdv_nxt;
    logic             vld_inc, err_inc;
    logic             run;
    logic             hs, store, good_pkt;
    logic [CNT_W-1:0] rd_addr;

    // run holds tready low through reset and releases it on the first edge afterwards
    assign tready_out = (state == IDLE) & run;
    assign hs         = tvalid_in & tready_out;
    assign store      = hs & (byte_cnt < CNT_W'(G_MEM_SIZE));
    // byte_cnt is the index of the current byte, so length = byte_cnt + 1 >= 8
    assign good_pkt   = hs & tlast_in & store & ~oversize & (byte_cnt >= CNT_W'(7));
    assign rd_addr    = idx[CNT_W-1:0];

    // Next-state and next-output decode; idx counts bytes within the current state
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        fcs_nxt   = fcs;
        txd_nxt   = 8'h00;
        txdv_nxt  = 1'b0;
        vld_inc   = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (hs && tlast_in) begin
                    if (good_pkt) begin
                        state_nxt = PCK_SFD;
                        idx_nxt   = '0;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            PCK_SFD: begin
                txdv_nxt = 1'b1;
                if (idx == IDX_W'(3)) begin
                    txd_nxt   = 8'h7F;
                    state_nxt = PCK_TYPE;
                    idx_nxt   = '0;
                end else begin
                    txd_nxt = 8'h55;
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            PCK_TYPE: begin
                txdv_nxt = 1'b1;
                if (idx == IDX_W'(1)) begin
                    txd_nxt   = 8'h34;
                    state_nxt = PCK_SIZE;
                    idx_nxt   = '0;
                end else begin
                    txd_nxt = 8'h12;
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            PCK_SIZE: begin
                txdv_nxt  = 1'b1;
                txd_nxt   = 8'(pkt_len);
                fcs_nxt   = 8'h00;
                state_nxt = PCK_PAYLOAD;
                idx_nxt   = '0;
            end
            PCK_PAYLOAD: begin
                txdv_nxt = 1'b1;
                txd_nxt  = mem[rd_addr];
                fcs_nxt  = fcs ^ mem[rd_addr];
                if (idx == IDX_W'(pkt_len - CNT_W'(1))) begin
                    state_nxt = PCK_FCS;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            PCK_FCS: begin
                txdv_nxt = 1'b1;
                txd_nxt  = fcs;
                vld_inc  = 1'b1;
`ifdef SIMPLE_TX_IFG_EN
                state_nxt = PCK_GAP;
                idx_nxt   = '0;
`else
                state_nxt = IDLE;
`endif
            end
            PCK_GAP: begin
                if (idx == IDX_W'(11)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, byte index, running FCS and registered line outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            idx      <= '0;
            fcs      <= 8'h00;
            txd_out  <= 8'h00;
            txdv_out <= 1'b0;
            run      <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            fcs      <= fcs_nxt;
            txd_out  <= txd_nxt;
            txdv_out <= txdv_nxt;
            run      <= 1'b1;
        end
    end

    // Saturating frame-sent and packet-dropped statistics
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_packet_vld_cnt <= 16'h0000;
            stat_packet_err_cnt <= 16'h0000;
        end else begin
            if (vld_inc && (stat_packet_vld_cnt != 16'hFFFF))
                stat_packet_vld_cnt <= stat_packet_vld_cnt + 16'd1;
            if (err_inc && (stat_packet_err_cnt != 16'hFFFF))
                stat_packet_err_cnt <= stat_packet_err_cnt + 16'd1;
        end
    end

    // Ingress byte count, oversize flag and captured packet length
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            byte_cnt <= '0;
            oversize <= 1'b0;
            pkt_len  <= '0;
        end else if (hs) begin
            if (tlast_in) begin
                byte_cnt <= '0;
                oversize <= 1'b0;
                if (good_pkt)
                    pkt_len <= byte_cnt + CNT_W'(1);
            end else if (store) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end else begin
                oversize <= 1'b1;
            end
        end
    end

    // Payload buffer write; contents need no reset since every frame rewrites what it reads
    always_ff @(posedge clk_in) begin
        if (store)
            mem[byte_cnt] <= tdata_in;
    end

endmodule

// File: tb/tb_simple_tx.sv
// Bench for simple_tx: table of packets driven through the stream port, line output checked against a byte scoreboard.
// Latency: expected frame pushed at the tlast byte, popped as txdv_out bytes appear.
// Backpressure: the driver waits (bounded) on tready_out before each byte.
module tb_simple_tx;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [7:0]  tdata_in;
    logic        tvalid_in;
    logic        tlast_in;
    logic        tready_out;
    logic [7:0]  txd_out;
    logic        txdv_out;
    logic [15:0] stat_packet_vld_cnt;
    logic [15:0] stat_packet_err_cnt;

    simple_tx #(.G_MEM_SIZE(100)) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .tdata_in            (tdata_in),
        .tvalid_in           (tvalid_in),
        .tlast_in            (tlast_in),
        .tready_out          (tready_out),
        .txd_out             (txd_out),
        .txdv_out            (txdv_out),
        .stat_packet_vld_cnt (stat_packet_vld_cnt),
        .stat_packet_err_cnt (stat_packet_err_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int len;
        int base;
        bit rnd;
        bit bub;
        bit exp_ok;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] exp_q [$];
    int         exp_len_q [$];
    int         remain;
    int         vectors;
    int         miscompares;
    int         vld_model;
    int         err_model;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] pl [$]);
        logic [7:0] f;
        f = 8'h00;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            f = f ^ pl[i];
        end
        exp_q.push_back(f);
        exp_len_q.push_back(pl.size() + 8);
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last);
        int w;
        tvalid_in = 1'b1;
        tdata_in  = d;
        tlast_in  = last;
        w = 0;
        while (!tready_out && w < 500) begin
            @(negedge clk_in);
            w++;
        end
        if (w >= 500) chk("tready_timeout", 0, 1);
        @(posedge clk_in);
        @(negedge clk_in);
        tvalid_in = 1'b0;
        tlast_in  = 1'b0;
        tdata_in  = 8'h00;
    endtask

    task automatic send_pkt(input int len, input int base, input bit rnd, input bit bub, input bit exp_ok);
        logic [7:0] pl [$];
        for (int i = 0; i < len; i++)
            pl.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(base + i));
        for (int i = 0; i < len; i++) begin
            if (bub && ($urandom_range(0, 2) == 0)) begin
                tvalid_in = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_in);
            end
            if (i == len - 1) begin
                if (exp_ok) begin
                    push_frame(pl);
                    vld_model++;
                end else begin
                    err_model++;
                end
            end
            drive_byte(pl[i], i == len - 1);
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while ((exp_len_q.size() != 0 || remain != 0) && w < 3000) begin
            @(negedge clk_in);
            #1;
            w++;
        end
        if (w >= 3000) chk("frame_timeout", 0, 1);
        repeat (3) @(negedge clk_in);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_vld_cnt"}, int'(stat_packet_vld_cnt), vld_model);
        chk({tag, "_err_cnt"}, int'(stat_packet_err_cnt), err_model);
    endtask

    initial begin
        int gap;
        int w;
        vectors     = 0;
        miscompares = 0;
        vld_model   = 0;
        err_model   = 0;
        remain      = 0;
        rst_n_in    = 1'b0;
        tvalid_in   = 1'b0;
        tlast_in    = 1'b0;
        tdata_in    = 8'h00;

        //              len  base  rnd bub ok
        tbl[0] = '{  8,    1,   0,  0, 1};
        tbl[1] = '{  5,    0,   0,  0, 0};
        tbl[2] = '{101,    0,   1,  0, 0};
        tbl[3] = '{100,    0,   1,  0, 1};
        tbl[4] = '{ 20,    0,   1,  1, 1};
        tbl[5] = '{  7,    0,   1,  0, 0};
        tbl[6] = '{  9, 8'h80,  0,  1, 1};
        tbl[7] = '{  1,    0,   0,  0, 0};
        tbl[8] = '{102,    0,   1,  1, 0};
        tbl[9] = '{ 50,    0,   1,  1, 1};

        // Line monitor: every txdv byte must match the scoreboard; frames must be gap-free
        fork
            forever begin
                @(negedge clk_in);
                if (!rst_n_in) begin
                    remain = 0;
                end else begin
                    if (remain == 0 && txdv_out) begin
                        if (exp_len_q.size() == 0) chk("unexpected_txdv", 1, 0);
                        else remain = exp_len_q.pop_front();
                    end
                    if (remain > 0) begin
                        chk("txdv_contig", int'(txdv_out), 1);
                        if (exp_q.size() > 0) chk("txd_byte", int'(txd_out), int'(exp_q.pop_front()));
                        remain--;
                    end else if (!txdv_out) begin
                        chk("txd_idle_zero", int'(txd_out), 0);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_tready", int'(tready_out), 0);
        chk("rst_txdv", int'(txdv_out), 0);
        chk("rst_txd", int'(txd_out), 0);
        chk_counters("rst");
        rst_n_in = 1'b1;
        #1;
        chk("rst_release_tready", int'(tready_out), 0);
        @(posedge clk_in);
        #1;
        chk("first_edge_tready", int'(tready_out), 1);
        @(negedge clk_in);

        // Table-driven packets
        for (int v = 0; v < 10; v++) begin
            send_pkt(tbl[v].len, tbl[v].base, tbl[v].rnd, tbl[v].bub, tbl[v].exp_ok);
            if (!tbl[v].exp_ok) begin
                #1;
                chk("drop_tready", int'(tready_out), 1);
            end
            wait_done();
            chk_counters($sformatf("vec%0d", v));
            chk("post_tready", int'(tready_out), 1);
        end

        // Back-to-back: count tready-low cycles after the FCS state cycle
        send_pkt(8, 8'h20, 0, 0, 1);
        w = 0;
        while (remain != 1 && w < 200) begin
            @(negedge clk_in);
            #1;
            w++;
        end
        if (w >= 200) chk("fcs_wait_timeout", 0, 1);
        gap = 0;
        w = 0;
        while (w < 50) begin
            @(negedge clk_in);
            #1;
            if (tready_out) break;
            chk("gap_txdv_low", int'(txdv_out), (gap == 0) ? 1 : 0);
            gap++;
            w++;
        end
`ifdef SIMPLE_TX_IFG_EN
        chk("ifg_cycles", gap, 12);
`else
        chk("ifg_cycles", gap, 0);
`endif
        send_pkt(10, 0, 1, 0, 1);
        wait_done();
        chk_counters("b2b");

        // Reset during payload byte 3 of a 20-byte frame
        send_pkt(20, 0, 1, 0, 1);
        w = 0;
        while (remain != 18 && w < 200) begin
            @(negedge clk_in);
            #1;
            w++;
        end
        if (w >= 200) chk("payload3_wait_timeout", 0, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_txdv", int'(txdv_out), 0);
        chk("midrst_txd", int'(txd_out), 0);
        chk("midrst_tready", int'(tready_out), 0);
        exp_q.delete();
        exp_len_q.delete();
        vld_model = 0;
        err_model = 0;
        chk_counters("midrst");
        @(negedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        send_pkt(12, 8'h40, 0, 1, 1);
        wait_done();
        chk_counters("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simple_tx.md
SIMPLE_TX -- requirements
Module: simple_tx

Interface
REQ-001 SHALL have parameter G_MEM_SIZE, default 100, payload buffer depth in bytes (maximum payload length).
REQ-002 SHALL have port clk_in  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tdata_in  input  8  stream payload byte.
REQ-005 SHALL have port tvalid_in  input  1  tdata_in valid.
REQ-006 SHALL have port tlast_in  input  1  last byte of packet.
REQ-007 SHALL have port tready_out  output  1  block accepts stream byte.
REQ-008 SHALL have port txd_out  output  8  line data byte.
REQ-009 SHALL have port txdv_out  output  1  txd_out valid.
REQ-010 SHALL have ports stat_packet_vld_cnt / stat_packet_err_cnt  output  16 each  frames sent / packets dropped.

Function
REQ-011 SHALL implement FSM states IDLE, PCK_SFD, PCK_TYPE, PCK_SIZE, PCK_PAYLOAD, PCK_FCS, PCK_GAP.
REQ-012 SHALL assert tready_out only in IDLE; handshake = tvalid_in & tready_out.
REQ-013 SHALL write each handshaken byte into the buffer at the next free address while count < G_MEM_SIZE; further bytes SHALL be accepted and discarded, packet marked oversize.
REQ-014 On tlast handshake at edge N with length L in 8..G_MEM_SIZE and not oversize, SHALL enter PCK_SFD at edge N; the first frame byte SHALL appear on txd_out with txdv_out=1 after edge N+1.
REQ-015 On tlast handshake with L<8 or oversize, SHALL drop the packet, stay in IDLE, increment stat_packet_err_cnt once, and reset the byte count.
REQ-016 Frame SHALL be contiguous, one byte per cycle, txdv_out=1 throughout: 0x55,0x55,0x55,0x7F (SFD), 0x12,0x34 (type), L (size), L payload bytes in arrival order, FCS; total L+8 cycles.
REQ-017 FCS SHALL be the 8-bit XOR of all L payload bytes.
REQ-018 txd_out and txdv_out SHALL be registered; txd_out SHALL be 0x00 whenever txdv_out=0.
REQ-019 stat_packet_vld_cnt SHALL increment on the cycle the FCS byte is driven.
REQ-020 Both counters SHALL saturate at 0xFFFF.
REQ-021 tvalid_in=0 mid-packet SHALL insert no gap in the eventual frame (store-and-forward).
REQ-022 tlast on the G_MEM_SIZE-th byte SHALL be a valid packet; tlast on byte G_MEM_SIZE+1 SHALL be oversize.

Reset
REQ-023 rst_n_in low SHALL immediately force IDLE, tready_out=0, txdv_out=0, txd_out=0x00, counters 0, byte count 0; tready_out SHALL rise on the first edge after release.
REQ-024 Reset mid-frame SHALL abort the frame at once with no further counter update; buffer contents are don't-care.

Configuration
REQ-025 With macro SIMPLE_TX_IFG_EN defined, after the FCS cycle the FSM SHALL spend exactly 12 cycles in PCK_GAP (txdv_out=0, tready_out=0) before IDLE.
REQ-026 Without SIMPLE_TX_IFG_EN, PCK_FCS SHALL go directly to IDLE; PCK_GAP is unreachable.

Verification
REQ-027 Payload 0x01..0x08 with tlast on 0x08 -> txd_out 55 55 55 7F 12 34 08 01 02 03 04 05 06 07 08 08, txdv_out high 16 cycles, vld_cnt=1.
REQ-028 5-byte packet -> no txdv_out, err_cnt=1, tready_out stays 1.
REQ-029 G_MEM_SIZE=100, 101-byte packet -> dropped, err_cnt=1; then 100-byte packet -> frame of 108 cycles, size byte 0x64.
REQ-030 Back-to-back packets with SIMPLE_TX_IFG_EN -> exactly 12 idle cycles after first FCS before tready_out=1; without macro, tready_out=1 the cycle after FCS.
REQ-031 Random tvalid_in bubbles on 20-byte packet -> frame contiguous, payload intact, FCS correct.
REQ-032 rst_n_in pulsed during payload byte 3 -> txdv_out=0 at once, counters 0, next packet sent correctly.
